// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use stall, multi-cycle memory freeze and branch flush control
//            for the 5-stage MIPS pipeline, plus a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             rs_id,
    input  logic [4:0]             rt_id,
    input  logic                   uses_rt_id,
    input  logic                   mem_read_ex,
    input  logic [4:0]             outReg_ex,
    input  logic                   nop_ex,
    input  logic                   mem_access_mem,
    input  logic                   nop_mem,
    input  logic                   branch_taken_id,
    input  logic                   clear_count,
    output logic                   stall_pc,
    output logic                   stall_if_id,
    output logic                   bubble_ex,
    output logic                   flush_if_id,
    output logic                   freeze,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
    localparam logic             C_MULTI     = (MEM_LATENCY > 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_mem_hit;
    logic w_freeze;
    logic w_hazard;
    logic w_load_use;

    assign w_mem_hit = mem_access_mem & ~nop_mem & C_MULTI;

    // On the release cycle (WAIT, counter 0) the access is leaving MEM, so mem_hit is ignored.
    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            ST_RUN:  w_freeze = w_mem_hit;
            ST_WAIT: w_freeze = (r_wait_cnt != '0);
            default: w_freeze = 1'b0;
        endcase
    end

    assign w_hazard = mem_read_ex & ~nop_ex & (outReg_ex != 5'd0) &
                      ((outReg_ex == rs_id) | (uses_rt_id & (outReg_ex == rt_id)));

    assign w_load_use = w_hazard & ~w_freeze;

    assign freeze      = ~reset & w_freeze;
    assign stall_pc    = ~reset & (w_freeze | w_load_use);
    assign stall_if_id = ~reset & (w_freeze | w_load_use);
    assign bubble_ex   = ~reset & w_load_use;
    assign flush_if_id = ~reset & branch_taken_id & ~w_hazard & ~w_freeze;
    assign stall_count = r_stall_cnt;
    assign state_o     = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_hit) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= C_WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (clear_count) begin
            r_stall_cnt <= '0;
        end else if (stall_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed and random stimulus for two hazard_stall_ctrl instances
//            (MEM_LATENCY 4 / 16-bit count and MEM_LATENCY 2 / 4-bit count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id, rt_id, outReg_ex;
    logic       uses_rt_id, mem_read_ex, nop_ex, mem_access_mem, nop_mem;
    logic       branch_taken_id, clear_count;

    logic        a_stall_pc, a_stall_if_id, a_bubble_ex, a_flush_if_id, a_freeze;
    logic [15:0] a_cnt;
    logic [1:0]  a_state;
    logic        b_stall_pc, b_stall_if_id, b_bubble_ex, b_flush_if_id, b_freeze;
    logic [3:0]  b_cnt;
    logic [1:0]  b_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: cycles the current access has already spent in MEM (0 = none).
    int res_a = 0, res_b = 0;
    int cnt_a = 0, cnt_b = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_LATENCY(4), .CNT_W(3), .STALL_CNT_W(16)) dut_l4 (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
        .mem_read_ex(mem_read_ex), .outReg_ex(outReg_ex), .nop_ex(nop_ex),
        .mem_access_mem(mem_access_mem), .nop_mem(nop_mem), .branch_taken_id(branch_taken_id),
        .clear_count(clear_count), .stall_pc(a_stall_pc), .stall_if_id(a_stall_if_id),
        .bubble_ex(a_bubble_ex), .flush_if_id(a_flush_if_id), .freeze(a_freeze),
        .stall_count(a_cnt), .state_o(a_state)
    );

    hazard_stall_ctrl #(.MEM_LATENCY(2), .CNT_W(3), .STALL_CNT_W(4)) dut_l2 (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
        .mem_read_ex(mem_read_ex), .outReg_ex(outReg_ex), .nop_ex(nop_ex),
        .mem_access_mem(mem_access_mem), .nop_mem(nop_mem), .branch_taken_id(branch_taken_id),
        .clear_count(clear_count), .stall_pc(b_stall_pc), .stall_if_id(b_stall_if_id),
        .bubble_ex(b_bubble_ex), .flush_if_id(b_flush_if_id), .freeze(b_freeze),
        .stall_count(b_cnt), .state_o(b_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit model_hit(input int ml);
        return mem_access_mem && !nop_mem && (ml > 1);
    endfunction

    function automatic bit model_hazard();
        return mem_read_ex && !nop_ex && (outReg_ex != 5'd0) &&
               ((outReg_ex == rs_id) || (uses_rt_id && (outReg_ex == rt_id)));
    endfunction

    // {stall_pc, stall_if_id, bubble_ex, flush_if_id, freeze, state[1:0]}
    function automatic logic [6:0] model_out(input int ml, input int res);
        bit frz, lu, stl;
        if (reset) return 7'd0;
        frz = (res == 0) ? model_hit(ml) : (res + 1 < ml);
        lu  = model_hazard() && !frz;
        stl = frz || lu;
        return {stl, stl, lu, (branch_taken_id && !model_hazard() && !frz), frz, 1'b0, (res != 0)};
    endfunction

    function automatic int model_next_res(input int ml, input int res);
        if (reset) return 0;
        if (res == 0) return model_hit(ml) ? 1 : 0;
        return (res + 1 >= ml) ? 0 : res + 1;
    endfunction

    function automatic int model_next_cnt(input int cnt, input bit stl, input int max);
        if (reset || clear_count) return 0;
        if (stl) return (cnt >= max) ? max : cnt + 1;
        return cnt;
    endfunction

    // Called just after a falling edge with inputs already driven; ends on the next falling edge.
    task automatic step();
        logic [6:0] exp_a, exp_b;
        #1;
        exp_a = model_out(4, res_a);
        exp_b = model_out(2, res_b);
        check_eq("ctl_l4", {25'd0, a_stall_pc, a_stall_if_id, a_bubble_ex, a_flush_if_id, a_freeze, a_state}, {25'd0, exp_a});
        check_eq("ctl_l2", {25'd0, b_stall_pc, b_stall_if_id, b_bubble_ex, b_flush_if_id, b_freeze, b_state}, {25'd0, exp_b});
        check_eq("cnt_l4", {16'd0, a_cnt}, reset ? 32'd0 : cnt_a);
        check_eq("cnt_l2", {28'd0, b_cnt}, reset ? 32'd0 : cnt_b);
        @(posedge clk);
        res_a = model_next_res(4, res_a);
        res_b = model_next_res(2, res_b);
        cnt_a = model_next_cnt(cnt_a, exp_a[6], 65535);
        cnt_b = model_next_cnt(cnt_b, exp_b[6], 15);
        @(negedge clk);
    endtask

    task automatic idle();
        rs_id = 5'd0; rt_id = 5'd0; outReg_ex = 5'd0; uses_rt_id = 1'b0;
        mem_read_ex = 1'b0; nop_ex = 1'b0; mem_access_mem = 1'b0; nop_mem = 1'b0;
        branch_taken_id = 1'b0; clear_count = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();

        // Load-use on rs, then the bubble reaches EX
        mem_read_ex = 1'b1; outReg_ex = 5'd5; rs_id = 5'd5;
        step();
        nop_ex = 1'b1;
        step();

        // $0 never hazards; rt ignored when not used
        nop_ex = 1'b0; outReg_ex = 5'd0; rs_id = 5'd0;
        step();
        outReg_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; uses_rt_id = 1'b0;
        step();
        uses_rt_id = 1'b1;
        step();
        idle();

        // Held memory access
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        mem_access_mem = 1'b1;
        repeat (4) step();
        mem_access_mem = 1'b0;
        step();

        // Load-use beats branch, then branch flushes alone
        mem_read_ex = 1'b1; outReg_ex = 5'd7; rs_id = 5'd7; branch_taken_id = 1'b1;
        step();
        mem_read_ex = 1'b0;
        step();
        idle();

        // Reset during the second freeze cycle
        mem_access_mem = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; mem_access_mem = 1'b0;
        repeat (2) step();

        // Saturation of the narrow counter, then clear during a stall
        mem_read_ex = 1'b1; outReg_ex = 5'd9; rs_id = 5'd9;
        repeat (17) step();
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        step();
        idle();

        for (int i = 0; i < 2000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            rs_id           = 5'($urandom_range(0, 3));
            rt_id           = 5'($urandom_range(0, 3));
            outReg_ex       = 5'($urandom_range(0, 3));
            uses_rt_id      = 1'($urandom_range(0, 1));
            mem_read_ex     = 1'($urandom_range(0, 1));
            nop_ex          = ($urandom_range(0, 3) == 0);
            mem_access_mem  = ($urandom_range(0, 3) == 0);
            nop_mem         = ($urandom_range(0, 3) == 0);
            branch_taken_id = 1'($urandom_range(0, 1));
            clear_count     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the EX/MEM forwarding selectors and covers the cases forwarding cannot resolve.
- Load-use hazards: stall PC and IF/ID, insert a bubble into ID/EX.
- Multi-cycle data-memory accesses: freeze the whole pipeline.
- Taken branches resolved in ID: flush IF/ID.
It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_LATENCY, 2, cycles a load/store occupies the MEM stage (legal range 1..8; 1 = single-cycle memory, never freezes)
CNT_W, 3, width of the internal memory-wait down-counter
STALL_CNT_W, 16, width of the stall_count output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rs_id  in  5  rs field of the instruction in ID
rt_id  in  5  rt field of the instruction in ID
uses_rt_id  in  1  ID instruction reads rt as a source
mem_read_ex  in  1  instruction in EX is a load
outReg_ex  in  5  destination register of the instruction in EX
nop_ex  in  1  EX slot holds a bubble
mem_access_mem  in  1  instruction in MEM is a load or store
nop_mem  in  1  MEM slot holds a bubble
branch_taken_id  in  1  branch/jump in ID resolved taken this cycle
clear_count  in  1  synchronous clear of stall_count
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
bubble_ex  out  1  load a nop into ID/EX instead of the ID instruction
flush_if_id  out  1  replace IF/ID content with a nop
freeze  out  1  hold every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
stall_count  out  STALL_CNT_W  saturating count of cycles with stall_pc=1
state_o  out  2  current FSM state (00 RUN, 01 WAIT), for debug

Behaviour:
- Clocking and reset: one clock domain. reset is asynchronous and active-high.
- While reset is high: state=RUN, wait counter=0, stall_count=0, and every output is forced to 0.
- FSM states: RUN and WAIT. All control outputs are Mealy, combinational from state, counter and inputs, with zero-cycle latency.
- mem_hit = mem_access_mem & ~nop_mem & (MEM_LATENCY>1).
- RUN with mem_hit:
  - freeze=1; stall_pc=stall_if_id=1; bubble_ex=0; flush_if_id=0.
  - Load counter with MEM_LATENCY-2; next state is WAIT.
- WAIT with counter != 0: freeze=1, stall_pc=stall_if_id=1, counter decrements, state stays WAIT.
- WAIT with counter == 0 (release cycle):
  - freeze=0; next state is RUN.
  - mem_hit is ignored this cycle, because the same access is leaving MEM.
  - Load-use and branch logic are evaluated normally.
- Freeze duration: exactly MEM_LATENCY-1 freeze cycles per access. Total MEM residency is MEM_LATENCY cycles.
- Load-use detection applies only when freeze=0. hazard = mem_read_ex & ~nop_ex & (outReg_ex!=0) & ((outReg_ex==rs_id) | (uses_rt_id & outReg_ex==rt_id)).
  - hazard=1 gives stall_pc=stall_if_id=bubble_ex=1 for that one cycle.
  - Next cycle EX holds a bubble, so the hazard clears without extra state.
- Register $0 never causes a hazard.
- Branch flush: flush_if_id = branch_taken_id & ~hazard & ~freeze.
  - Load-use wins over a simultaneous branch. The branch re-resolves after the stall.
- Priority order: freeze > load-use > branch flush.
- Under freeze: bubble_ex=0 and flush_if_id=0.
- stall_count:
  - +1 on every clock edge where stall_pc=1, saturating at all-ones.
  - clear_count=1 sets it to 0 and overrides the increment.
- Reset asserted mid-WAIT: immediate return to RUN. No residual freeze after reset is released.

Test Plan:
- MEM_LATENCY=2; load to r5 in EX (mem_read_ex=1, outReg_ex=5, nop_ex=0); ID rs_id=5 -> stall_pc=stall_if_id=bubble_ex=1 for exactly 1 cycle; stall_count 0->1.
- Same as above but outReg_ex=0, rs_id=0 -> no stall. Then uses_rt_id=0, rt_id=5 with rs_id=3 -> no stall.
- MEM_LATENCY=4; mem_access_mem=1 and nop_mem=0 held -> freeze=1 for 3 consecutive cycles, then 1 release cycle with freeze=0; state_o sequence 00,01,01,01 then 00; stall_count=3.
- Load-use hazard and branch_taken_id=1 in the same cycle -> bubble_ex=1, flush_if_id=0. Next cycle, branch_taken_id=1 with no hazard -> flush_if_id=1, stall_pc=0.
- MEM_LATENCY=4; assert reset in the 2nd freeze cycle -> all outputs 0 at once. After reset is released with mem_access_mem=0 -> state_o=00, freeze stays 0.
- stall_count forced near saturation (STALL_CNT_W=4, 15 stall cycles then 2 more) -> stays at 15. clear_count=1 during a stall cycle -> reads 0 next cycle.
